cache_refill_arbiter: RTL and testbench

- Shares one burst-read memory port between the ICache and DCache line-refill requesters.
- Grants one requester at a time and issues a line-aligned 8-beat incrementing read burst.
- Assembles the 32-bit beats into a 256-bit line and returns it to the granted requester with a one-cycle valid pulse.
- Sits between the two caches' miss paths and the bus interface unit.

---
 rtl/cache_refill_arbiter_pkg.sv | 36 +++
 rtl/cache_refill_arbiter_assembler.sv | 54 +++++
 rtl/cache_refill_arbiter.sv | 108 ++++++++++
 tb/tb_cache_refill_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_refill_arbiter_pkg.sv
// Shared cache refill definitions: line geometry, refill FSM states, requester IDs
// and the small helpers used by the refill arbiter.
package cache_refill_arbiter_pkg;

    localparam int WORD_W     = 32;
    localparam int LINE_WORDS = 8;
    localparam int OFFSET_W   = 5;
    localparam int LINE_W     = WORD_W * LINE_WORDS;  // also the ICache WayBus width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } refill_state_e;

    typedef enum logic {
        REQ_ICACHE = 1'b0,
        REQ_DCACHE = 1'b1
    } req_id_e;

    // Round-robin pick; only meaningful when at least one request is present.
    function automatic req_id_e rr_pick(input logic ic_req, input logic dc_req,
                                        input req_id_e last_grant);
        req_id_e pick;
        if (ic_req && dc_req) begin
            pick = (last_grant == REQ_ICACHE) ? REQ_DCACHE : REQ_ICACHE;
        end else if (ic_req) begin
            pick = REQ_ICACHE;
        end else begin
            pick = REQ_DCACHE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/cache_refill_arbiter_assembler.sv
// Refill line assembler: counts read beats, inserts each 32-bit beat into the
// line register and checks the bus rlast marker against the local beat count.
module refill_line_assembler #(
    parameter int LINE_WORDS = cache_refill_arbiter_pkg::LINE_WORDS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      beat_en,
    input  logic [31:0]               beat_data,
    input  logic                      beat_last,
    output logic [32*LINE_WORDS-1:0]  line,
    output logic                      done,
    output logic                      err
);
    import cache_refill_arbiter_pkg::*;

    localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    logic [CNT_W-1:0]                  beat_cnt;
    logic [LINE_WORDS-1:0][WORD_W-1:0] line_q;
    logic                              is_last;

    assign is_last = (beat_cnt == LAST_BEAT);
    // Completion follows the local count only; rlast is merely cross-checked.
    assign done    = beat_en && is_last;
    assign line    = line_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            // NOTE: the line register is reset despite being storage because it
            // drives the rdata outputs directly, which must read zero after reset.
            line_q   <= '0;
            err      <= 1'b0;
        end else begin
            if (start) begin
                beat_cnt <= '0;
            end else if (beat_en) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (beat_en) begin
                line_q[beat_cnt] <= beat_data;
                if (beat_last != is_last) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Refill arbiter: shares one burst-read port between ICache and DCache misses,
// issues an aligned line burst and returns the assembled line to the winner.
module cache_refill_arbiter #(
    parameter int LINE_WORDS = cache_refill_arbiter_pkg::LINE_WORDS,
    parameter int ADDR_W     = 32,
    parameter int OFFSET_W   = cache_refill_arbiter_pkg::OFFSET_W
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      ic_ren_i,
    input  logic [ADDR_W-1:0]         ic_araddr_i,
    output logic                      ic_rvalid_o,
    output logic [32*LINE_WORDS-1:0]  ic_rdata_o,

    input  logic                      dc_ren_i,
    input  logic [ADDR_W-1:0]         dc_araddr_i,
    output logic                      dc_rvalid_o,
    output logic [32*LINE_WORDS-1:0]  dc_rdata_o,

    output logic                      arvalid_o,
    output logic [ADDR_W-1:0]         araddr_o,
    output logic [7:0]                arlen_o,
    input  logic                      arready_i,
    input  logic                      rvalid_i,
    input  logic [31:0]               rdata_i,
    input  logic                      rlast_i,
    output logic                      rready_o,
    output logic                      err_o
);
    import cache_refill_arbiter_pkg::*;

    refill_state_e            state_q, state_d;
    req_id_e                  last_grant_q, pick;
    logic [ADDR_W-1:0]        araddr_q, sel_addr;
    logic [32*LINE_WORDS-1:0] line;
    logic                     grant_now, ar_fire, beat_en, line_done;

    assign grant_now = (state_q == ST_IDLE) && (ic_ren_i || dc_ren_i);
    assign pick      = rr_pick(ic_ren_i, dc_ren_i, last_grant_q);
    assign sel_addr  = (pick == REQ_ICACHE) ? ic_araddr_i : dc_araddr_i;
    assign ar_fire   = (state_q == ST_ADDR) && arready_i;
    assign beat_en   = (state_q == ST_DATA) && rvalid_i;

    // last_grant_q doubles as the owner of the burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= REQ_DCACHE;
            araddr_q     <= '0;
        end else begin
            state_q <= state_d;
            if (grant_now) begin
                last_grant_q <= pick;
                araddr_q     <= {sel_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        arvalid_o   = 1'b0;
        rready_o    = 1'b0;
        ic_rvalid_o = 1'b0;
        dc_rvalid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_now) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                arvalid_o = 1'b1;
                if (arready_i) state_d = ST_DATA;
            end
            ST_DATA: begin
                rready_o = 1'b1;
                if (line_done) state_d = ST_RESP;
            end
            ST_RESP: begin
                ic_rvalid_o = (last_grant_q == REQ_ICACHE);
                dc_rvalid_o = (last_grant_q == REQ_DCACHE);
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    refill_line_assembler #(
        .LINE_WORDS (LINE_WORDS)
    ) u_assembler (
        .clk        (clk),
        .rst        (rst),
        .start      (ar_fire),
        .beat_en    (beat_en),
        .beat_data  (rdata_i),
        .beat_last  (rlast_i),
        .line       (line),
        .done       (line_done),
        .err        (err_o)
    );

    assign araddr_o   = araddr_q;
    assign arlen_o    = 8'(LINE_WORDS - 1);
    assign ic_rdata_o = line;
    assign dc_rdata_o = line;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Self-checking bench for cache_refill_arbiter: directed scenarios plus a random
// phase, all compared every cycle against a transaction-level reference model.
module tb_cache_refill_arbiter;
    localparam int LW = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         ic_ren_i, dc_ren_i, ic_rvalid_o, dc_rvalid_o;
    logic [31:0]  ic_araddr_i, dc_araddr_i;
    logic [255:0] ic_rdata_o, dc_rdata_o;
    logic         arvalid_o, arready_i, rvalid_i, rlast_i, rready_o, err_o;
    logic [31:0]  araddr_o, rdata_i;
    logic [7:0]   arlen_o;

    always #5 clk = ~clk;

    cache_refill_arbiter dut (
        .clk(clk), .rst(rst),
        .ic_ren_i(ic_ren_i), .ic_araddr_i(ic_araddr_i), .ic_rvalid_o(ic_rvalid_o), .ic_rdata_o(ic_rdata_o),
        .dc_ren_i(dc_ren_i), .dc_araddr_i(dc_araddr_i), .dc_rvalid_o(dc_rvalid_o), .dc_rdata_o(dc_rdata_o),
        .arvalid_o(arvalid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arready_i(arready_i),
        .rvalid_i(rvalid_i), .rdata_i(rdata_i), .rlast_i(rlast_i), .rready_o(rready_o), .err_o(err_o)
    );

    int total = 0, bad = 0, cyc = 0;

    // Reference model: one outstanding refill, described by flags and a beat count.
    bit          m_busy, m_addr_ph, m_resp, m_err;
    int          m_beats, m_who;
    logic [31:0] m_addr;
    logic [31:0] m_line [LW];

    // Bus slave / requester stimulus state.
    int          s_beat, s_ar_cnt, s_gap, ar_delay, gap_len, bad_beat, req_mode;
    bit          rand_bus, gap_mask [LW];
    logic [31:0] data_base, exp_araddr;
    bit          exp_ar_valid;
    int          grants[$];
    int          resp_cyc, beat7_cyc, arv_cycles, t0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [255:0] model_line();
        logic [255:0] v;
        for (int k = 0; k < LW; k++) v[32*k +: 32] = m_line[k];
        return v;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_busy = 0; m_addr_ph = 0; m_resp = 0; m_err = 0;
            m_beats = 0; m_who = 1; m_addr = '0;
            for (int k = 0; k < LW; k++) m_line[k] = '0;
        end else if (m_resp) begin
            m_resp = 0; m_busy = 0;
        end else if (!m_busy) begin
            if (ic_ren_i || dc_ren_i) begin
                if (ic_ren_i && dc_ren_i) m_who = 1 - m_who;
                else                      m_who = ic_ren_i ? 0 : 1;
                m_addr    = (m_who == 0 ? ic_araddr_i : dc_araddr_i) & 32'hFFFF_FFE0;
                m_busy    = 1;
                m_addr_ph = 1;
            end
        end else if (m_addr_ph) begin
            if (arready_i) begin m_addr_ph = 0; m_beats = 0; end
        end else if (rvalid_i) begin
            m_line[m_beats] = rdata_i;
            if (rlast_i != (m_beats == LW-1)) m_err = 1;
            m_beats++;
            if (m_beats == LW) m_resp = 1;
        end
    endtask

    task automatic compare();
        check("arvalid",   256'(arvalid_o),   256'(m_busy && m_addr_ph));
        check("rready",    256'(rready_o),    256'(m_busy && !m_addr_ph && !m_resp));
        check("ic_rvalid", 256'(ic_rvalid_o), 256'(m_resp && m_who == 0));
        check("dc_rvalid", 256'(dc_rvalid_o), 256'(m_resp && m_who == 1));
        check("araddr",    256'(araddr_o),    256'(m_addr));
        check("arlen",     256'(arlen_o),     256'(LW-1));
        check("err",       256'(err_o),       256'(m_err));
        check("ic_rdata",  ic_rdata_o,        model_line());
        check("dc_rdata",  dc_rdata_o,        model_line());
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare();
        if (ic_rvalid_o) begin grants.push_back(0); resp_cyc = cyc; end
        if (dc_rvalid_o) begin grants.push_back(1); resp_cyc = cyc; end
        if (arvalid_o) begin
            arv_cycles++;
            if (exp_ar_valid) check("araddr_lit", 256'(araddr_o), 256'(exp_araddr));
        end
    endtask

    task automatic drive();
        if (ic_ren_i && ic_rvalid_o) ic_ren_i = 0;
        else if (!ic_ren_i && (req_mode == 1 || (req_mode == 2 && $urandom_range(0, 3) == 0))) begin
            ic_ren_i = 1;
            if (req_mode == 2) ic_araddr_i = $urandom;
        end
        if (dc_ren_i && dc_rvalid_o) dc_ren_i = 0;
        else if (!dc_ren_i && (req_mode == 1 || (req_mode == 2 && $urandom_range(0, 3) == 0))) begin
            dc_ren_i = 1;
            if (req_mode == 2) dc_araddr_i = $urandom;
        end
        arready_i = 0;
        if (arvalid_o) begin
            arready_i = rand_bus ? ($urandom_range(0, 1) == 1) : (s_ar_cnt >= ar_delay);
            s_ar_cnt++;
            if (arready_i) begin s_ar_cnt = 0; s_beat = 0; s_gap = 0; end
        end
        rvalid_i = 0; rdata_i = '0; rlast_i = 0;
        if (rready_o && s_beat < LW) begin
            if (s_gap > 0) s_gap--;
            else if (!rand_bus || $urandom_range(0, 2) != 0) begin
                rvalid_i = 1;
                rdata_i  = rand_bus ? $urandom : data_base + s_beat;
                rlast_i  = (s_beat == LW-1) ^ (s_beat == bad_beat);
                if (s_beat == LW-1) beat7_cyc = cyc;
                if (gap_mask[s_beat]) s_gap = gap_len;
                s_beat++;
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1; ic_ren_i = 0; dc_ren_i = 0;
        arready_i = 0; rvalid_i = 0; rdata_i = '0; rlast_i = 0;
        s_beat = 0; s_ar_cnt = 0; s_gap = 0;
        repeat (n) tick();
        rst = 0;
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int i = 0;
        while (grants.size() < n && i < budget) begin drive(); tick(); i++; end
        check({tag, "_done"}, 256'(grants.size() >= n), 256'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin drive(); tick(); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1; ic_ren_i = 0; dc_ren_i = 0; ic_araddr_i = '0; dc_araddr_i = '0;
        arready_i = 0; rvalid_i = 0; rdata_i = '0; rlast_i = 0;
        rand_bus = 0; req_mode = 0; ar_delay = 0; gap_len = 0; bad_beat = -1;
        data_base = '0; exp_araddr = '0; exp_ar_valid = 0;
        s_beat = 0; s_ar_cnt = 0; s_gap = 0; resp_cyc = -1; beat7_cyc = -1; arv_cycles = 0;
        for (int k = 0; k < LW; k++) gap_mask[k] = 0;
        m_busy = 0; m_addr_ph = 0; m_resp = 0; m_err = 0; m_beats = 0; m_who = 1; m_addr = '0;
        for (int k = 0; k < LW; k++) m_line[k] = '0;
        @(negedge clk);

        // Reset state.
        do_reset(3);
        check("rst_arvalid", 256'(arvalid_o), 256'(0));
        check("rst_rready",  256'(rready_o),  256'(0));
        check("rst_rvalid",  256'({ic_rvalid_o, dc_rvalid_o}), 256'(0));
        check("rst_err",     256'(err_o),     256'(0));
        check("rst_araddr",  256'(araddr_o),  256'(0));
        check("rst_rdata",   ic_rdata_o | dc_rdata_o, 256'(0));

        // ICache only, zero-wait bus.
        grants.delete(); data_base = 32'hA0;
        exp_araddr = 32'h1FC0_0000; exp_ar_valid = 1;
        ic_araddr_i = 32'h1FC0_0014; ic_ren_i = 1; t0 = cyc;
        run_until(1, 40, "t1");
        check("t1_latency", 256'(resp_cyc - t0), 256'(10));
        check("t1_arlen",   256'(arlen_o), 256'(8'd7));
        check("t1_word0",   256'(ic_rdata_o[31:0]),    256'(32'hA0));
        check("t1_word7",   256'(ic_rdata_o[255:224]), 256'(32'hA7));
        idle(4);
        check("t1_only_ic", 256'({grants.size(), (grants.size() > 0) ? grants[0] : 9}), {224'd0, 32'd1, 32'd0});
        exp_ar_valid = 0;

        // Both requesters in the same IDLE cycle right after reset.
        do_reset(2); grants.delete(); data_base = 32'h10;
        ic_araddr_i = 32'h0000_1234; dc_araddr_i = 32'h4000_5678;
        ic_ren_i = 1; dc_ren_i = 1;
        run_until(2, 60, "t2");
        idle(4);
        check("t2_count", 256'(grants.size()), 256'(2));
        if (grants.size() >= 2) begin
            check("t2_first",  256'(grants[0]), 256'(0));
            check("t2_second", 256'(grants[1]), 256'(1));
        end

        // Both requesters re-requesting continuously: grants alternate.
        do_reset(2); grants.delete(); req_mode = 1; data_base = 32'h200;
        run_until(4, 120, "t3");
        req_mode = 0;
        for (int k = 0; k < 4 && k < grants.size(); k++)
            check($sformatf("t3_grant%0d", k), 256'(grants[k]), 256'(k % 2));

        // Address handshake delayed 3 cycles, beat gaps after beats 2 and 5.
        do_reset(2); grants.delete(); data_base = 32'hC0;
        ar_delay = 3; gap_len = 2; gap_mask[2] = 1; gap_mask[5] = 1;
        exp_araddr = 32'h8000_1060; exp_ar_valid = 1; arv_cycles = 0;
        dc_araddr_i = 32'h8000_107C; dc_ren_i = 1;
        run_until(1, 80, "t4");
        check("t4_arv_cycles", 256'(arv_cycles), 256'(4));
        check("t4_resp_after_last", 256'(resp_cyc - beat7_cyc), 256'(1));
        for (int k = 0; k < LW; k++)
            check($sformatf("t4_word%0d", k), 256'(dc_rdata_o[32*k +: 32]), 256'(32'hC0 + k));
        ar_delay = 0; gap_len = 0; gap_mask[2] = 0; gap_mask[5] = 0; exp_ar_valid = 0;
        idle(2);

        // rlast on beat 5: sticky error, burst still completes on the count.
        do_reset(2); grants.delete(); data_base = 32'h30; bad_beat = 5;
        ic_araddr_i = 32'h0000_0040; ic_ren_i = 1;
        run_until(1, 60, "t5");
        bad_beat = -1;
        check("t5_err",   256'(err_o), 256'(1));
        check("t5_word7", 256'(ic_rdata_o[255:224]), 256'(32'h37));
        idle(6);
        check("t5_err_sticky", 256'(err_o), 256'(1));

        // Reset in DATA after 4 beats, then a clean ICache refill.
        do_reset(2); grants.delete(); data_base = 32'h70;
        ic_araddr_i = 32'h2000_0000; ic_ren_i = 1;
        for (int i = 0; i < 40 && s_beat < 4; i++) begin drive(); tick(); end
        check("t6_mid_beats", 256'(s_beat), 256'(4));
        do_reset(1);
        check("t6_rready",  256'(rready_o),  256'(0));
        check("t6_arvalid", 256'(arvalid_o), 256'(0));
        check("t6_rvalid",  256'({ic_rvalid_o, dc_rvalid_o}), 256'(0));
        grants.delete(); data_base = 32'h50;
        ic_araddr_i = 32'h2000_0100; ic_ren_i = 1;
        run_until(1, 60, "t6");
        check("t6_word0", 256'(ic_rdata_o[31:0]),    256'(32'h50));
        check("t6_word7", 256'(ic_rdata_o[255:224]), 256'(32'h57));
        idle(3);

        // Random requesters, random bus stalls, rare resets.
        do_reset(2); grants.delete(); rand_bus = 1; req_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) do_reset(1);
            else begin drive(); tick(); end
        end
        check("rand_progress", 256'(grants.size() >= 20), 256'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
